// File: rtl/stair_scheduler.sv
// stair_scheduler
//   Owns the shared VGA pixel-write port for NUM_STAIRS rectangular stairs.
//   Each animation step draws every stair, waits for frame_tick, erases every
//   stair, scrolls each stair up by STEP rows (wrapping to Y_WRAP), then draws
//   again. One pixel is issued per clock; all pixel outputs are registered.
//
// Ports
//   clock         system clock
//   reset_n       synchronous active-low reset (reloads stair y from stair_y_in)
//   go            start request, press-and-release
//   frame_tick    one-cycle pulse from the frame counter
//   stair_x_in    x of stair i at [8i+7:8i], sampled live
//   stair_y_in    initial y of stair i at [7i+6:7i], loaded at reset
//   stair_colour  (STAIR_SCHED_COLOUR_EN only) draw colour of stair i at [3i+2:3i]
//   x, y, colour  pixel coordinate and colour
//   plot          pixel write enable
//   frame_done    pulses with the last registered pixel of a draw pass
//   current_state FSM state for debug
//
// Configuration macro: STAIR_SCHED_COLOUR_EN adds per-stair draw colours;
// without it every stair draws in 3'b100.
module stair_scheduler #(
  parameter int NUM_STAIRS = 2,
  parameter int STAIR_W    = 40,
  parameter int STAIR_H    = 5,
  parameter int STEP       = 1,
  parameter int Y_WRAP     = 116
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic                    frame_tick,
  input  logic [8*NUM_STAIRS-1:0] stair_x_in,
  input  logic [7*NUM_STAIRS-1:0] stair_y_in,
`ifdef STAIR_SCHED_COLOUR_EN
  input  logic [3*NUM_STAIRS-1:0] stair_colour,
`endif
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [2:0]              colour,
  output logic                    plot,
  output logic                    frame_done,
  output logic [2:0]              current_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GO_WAIT    = 3'd1,
    DRAW       = 3'd2,
    WAIT_FRAME = 3'd3,
    ERASE      = 3'd4,
    UPDATE     = 3'd5
  } state_t;

  localparam int IW = (NUM_STAIRS > 1) ? $clog2(NUM_STAIRS) : 1;
  localparam int PW = (STAIR_W > 1) ? $clog2(STAIR_W) : 1;
  localparam int HW = (STAIR_H > 1) ? $clog2(STAIR_H) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_STAIRS - 1);
  localparam logic [PW-1:0] PX_LAST  = PW'(STAIR_W - 1);
  localparam logic [HW-1:0] PY_LAST  = HW'(STAIR_H - 1);
  localparam logic [6:0]    STEP_Y   = 7'(STEP);
  localparam logic [6:0]    WRAP_Y   = 7'(Y_WRAP);

  state_t        state_r, state_next_s;
  logic [IW-1:0] idx_r;
  logic [PW-1:0] px_r;
  logic [HW-1:0] py_r;
  logic [6:0]    stair_y_r [NUM_STAIRS];
  logic [7:0]    stair_x_s [NUM_STAIRS];
  logic [2:0]    draw_colour_s [NUM_STAIRS];
  logic          sweep_s;
  logic          last_s;
  logic [2:0]    pixel_colour_s;

  // Unpack the flat per-stair input buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_STAIRS; i++) begin
      stair_x_s[i] = stair_x_in[8*i +: 8];
`ifdef STAIR_SCHED_COLOUR_EN
      draw_colour_s[i] = stair_colour[3*i +: 3];
`else
      draw_colour_s[i] = 3'b100;
`endif
    end
  end

  // Next-state logic plus sweep control; last_s marks the final pixel of a pass.
  always_comb begin
    state_next_s   = state_r;
    sweep_s        = (state_r == DRAW) || (state_r == ERASE);
    last_s         = sweep_s && (idx_r == IDX_LAST) && (py_r == PY_LAST) && (px_r == PX_LAST);
    pixel_colour_s = 3'b000;
    if (state_r == DRAW) begin
      pixel_colour_s = draw_colour_s[idx_r];
    end else begin
      pixel_colour_s = 3'b000;
    end
    case (state_r)
      IDLE:       if (go) state_next_s = GO_WAIT; else state_next_s = IDLE;
      GO_WAIT:    if (!go) state_next_s = DRAW; else state_next_s = GO_WAIT;
      DRAW:       if (last_s) state_next_s = WAIT_FRAME; else state_next_s = DRAW;
      WAIT_FRAME: if (frame_tick) state_next_s = ERASE; else state_next_s = WAIT_FRAME;
      ERASE:      if (last_s) state_next_s = UPDATE; else state_next_s = ERASE;
      UPDATE:     state_next_s = DRAW;
      default:    state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_r <= IDLE;
    else          state_r <= state_next_s;
  end

  // Sweep counters: px fastest, then py, then stair index; parked at zero between passes.
  always_ff @(posedge clock) begin
    if (!reset_n || !sweep_s) begin
      idx_r <= '0;
      px_r  <= '0;
      py_r  <= '0;
    end else if (px_r != PX_LAST) begin
      px_r <= px_r + 1'b1;
    end else begin
      px_r <= '0;
      if (py_r != PY_LAST) begin
        py_r <= py_r + 1'b1;
      end else begin
        py_r <= '0;
        if (idx_r != IDX_LAST) idx_r <= idx_r + 1'b1;
        else                   idx_r <= '0;
      end
    end
  end

  // Registered pixel port; coordinates wrap silently and hold while idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x          <= 8'd0;
      y          <= 7'd0;
      colour     <= 3'b000;
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end else if (sweep_s) begin
      x          <= stair_x_s[idx_r] + 8'(px_r);
      y          <= stair_y_r[idx_r] + 7'(py_r);
      colour     <= pixel_colour_s;
      plot       <= 1'b1;
      frame_done <= last_s && (state_r == DRAW);
    end else begin
      plot       <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  // Per-stair y: loaded at reset, scrolled up once per UPDATE with wrap to Y_WRAP.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_STAIRS; i++) begin
      if (!reset_n) begin
        stair_y_r[i] <= stair_y_in[7*i +: 7];
      end else if (state_r == UPDATE) begin
        if (stair_y_r[i] < STEP_Y) stair_y_r[i] <= WRAP_Y;
        else                       stair_y_r[i] <= stair_y_r[i] - STEP_Y;
      end
    end
  end

  assign current_state = state_r;

endmodule

// File: tb/tb_stair_scheduler.sv
module tb_stair_scheduler;

  localparam int N = 2;
  localparam int W = 4;
  localparam int H = 2;
  localparam int PIX = N * W * H;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         go;
  logic         frame_tick;
  logic [15:0]  stair_x_in;
  logic [13:0]  stair_y_in;
`ifdef STAIR_SCHED_COLOUR_EN
  logic [5:0]   stair_colour = {3'b010, 3'b001};
`endif
  logic [7:0]   x;
  logic [6:0]   y;
  logic [2:0]   colour;
  logic         plot;
  logic         frame_done;
  logic [2:0]   current_state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       tick;
    int         ex;
    int         ey;
    int         ec;
    int         efd;
    int         est;
  } vec_t;

  vec_t tbl [PIX];

  stair_scheduler #(.NUM_STAIRS(N), .STAIR_W(W), .STAIR_H(H), .STEP(1), .Y_WRAP(116)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .go(go),
    .frame_tick(frame_tick),
    .stair_x_in(stair_x_in),
    .stair_y_in(stair_y_in),
`ifdef STAIR_SCHED_COLOUR_EN
    .stair_colour(stair_colour),
`endif
    .x(x),
    .y(y),
    .colour(colour),
    .plot(plot),
    .frame_done(frame_done),
    .current_state(current_state)
  );

  always #5 clock = ~clock;

  function automatic int draw_col(input int s);
`ifdef STAIR_SCHED_COLOUR_EN
    return (s == 0) ? 1 : 2;
`else
    return 4;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [13:0] yin);
    reset_n    = 1'b0;
    stair_y_in = yin;
    tick_clk();
    reset_n    = 1'b1;
  endtask

  task automatic start();
    go = 1'b1;
    tick_clk();
    chk("go_wait_state", int'(current_state), 1);
    go = 1'b0;
    tick_clk();
    chk("draw_entry_state", int'(current_state), 2);
    chk("draw_entry_plot", int'(plot), 0);
  endtask

  // Checks npix consecutive pixels of a pass whose stair bases are y0/y1.
  task automatic check_pass(input bit erase, input int y0, input int y1, input int npix);
    int s, r, c, ex, ey, ec, est;
    for (int j = 0; j < npix; j++) begin
      tick_clk();
      s  = j / (W * H);
      r  = (j % (W * H)) / W;
      c  = j % W;
      ex = ((s == 0) ? 60 : 80) + c;
      ey = (((s == 0) ? y0 : y1) + r) % 128;
      ec = erase ? 0 : draw_col(s);
      if (j == PIX - 1) est = erase ? 5 : 3;
      else              est = erase ? 4 : 2;
      chk("pass_plot", int'(plot), 1);
      chk("pass_x", int'(x), ex);
      chk("pass_y", int'(y), ey);
      chk("pass_colour", int'(colour), ec);
      chk("pass_frame_done", int'(frame_done), (!erase && j == PIX - 1) ? 1 : 0);
      chk("pass_state", int'(current_state), est);
    end
  endtask

  initial begin
    // First draw pass; frame_tick pulsed mid-pass and on the last pixel must be ignored.
    for (int j = 0; j < PIX; j++) begin
      tbl[j].tick = (j == 4) || (j == PIX - 1);
      tbl[j].ex   = ((j / 8) == 0 ? 60 : 80) + (j % 4);
      tbl[j].ey   = ((j / 8) == 0 ? 40 : 20) + ((j % 8) / 4);
      tbl[j].ec   = draw_col(j / 8);
      tbl[j].efd  = (j == PIX - 1) ? 1 : 0;
      tbl[j].est  = (j == PIX - 1) ? 3 : 2;
    end

    stair_x_in = {8'd80, 8'd60};
    stair_y_in = {7'd20, 7'd40};
    go         = 1'b0;
    frame_tick = 1'b0;
    reset_n    = 1'b0;
    tick_clk();
    tick_clk();
    chk("reset_state", int'(current_state), 0);
    chk("reset_plot", int'(plot), 0);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_colour", int'(colour), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;
    tick_clk();
    chk("idle_hold", int'(current_state), 0);

    start();
    for (int j = 0; j < PIX; j++) begin
      frame_tick = tbl[j].tick;
      tick_clk();
      frame_tick = 1'b0;
      chk("tbl_plot", int'(plot), 1);
      chk("tbl_x", int'(x), tbl[j].ex);
      chk("tbl_y", int'(y), tbl[j].ey);
      chk("tbl_colour", int'(colour), tbl[j].ec);
      chk("tbl_frame_done", int'(frame_done), tbl[j].efd);
      chk("tbl_state", int'(current_state), tbl[j].est);
    end

    // Parked in WAIT_FRAME with outputs holding the last pixel.
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      chk("wait_state", int'(current_state), 3);
      chk("wait_plot", int'(plot), 0);
      chk("wait_frame_done", int'(frame_done), 0);
      chk("wait_x_hold", int'(x), 83);
      chk("wait_y_hold", int'(y), 21);
    end

    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    chk("erase_entry_state", int'(current_state), 4);
    chk("erase_entry_plot", int'(plot), 0);
    check_pass(1'b1, 40, 20, PIX);
    tick_clk();
    chk("update_exit_state", int'(current_state), 2);
    chk("update_plot", int'(plot), 0);
    check_pass(1'b0, 39, 19, PIX);

    // Reset asserted at the 5th draw pixel abandons the sweep.
    do_reset({7'd20, 7'd40});
    start();
    check_pass(1'b0, 40, 20, 4);
    reset_n = 1'b0;
    tick_clk();
    reset_n = 1'b1;
    chk("midreset_plot", int'(plot), 0);
    chk("midreset_state", int'(current_state), 0);
    chk("midreset_x", int'(x), 0);
    start();
    check_pass(1'b0, 40, 20, 1);

    // Stair 0 at y=0 wraps to Y_WRAP after the first UPDATE.
    do_reset({7'd20, 7'd0});
    start();
    check_pass(1'b0, 0, 20, PIX);
    frame_tick = 1'b1;
    tick_clk();
    frame_tick = 1'b0;
    check_pass(1'b1, 0, 20, PIX);
    tick_clk();
    check_pass(1'b0, 116, 19, PIX);

    // Stair 0 at y=127: row 1 wraps to y=0.
    do_reset({7'd20, 7'd127});
    start();
    check_pass(1'b0, 127, 20, PIX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
